key_event_queue: RTL and testbench

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/key_event_queue.sv | 209 ++++++++++++++++++++
 tb/tb_key_event_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_event_queue.sv
// key_event_queue: turns a debounced keypad "one key down" flag into press and
// auto-repeat events, and buffers them in a 4-entry first-word-fall-through queue.
// Latency: a valid key sampled at edge N is visible on ev_* after edge N.
// Backpressure: none toward the scanner. A push into a full queue is dropped
// (pulses overflow) unless pop frees the head in the same cycle.
//
// Ports:
//   clk, rstn     system clock, async active-low reset
//   key_ready     scanner reports exactly one key down
//   key_code      scanner code: [4:2] row (7 = invalid), [1:0] column
//   pop           consumer takes the head entry (ignored when empty)
//   ev_valid      queue non-empty
//   ev_code       head entry code
//   ev_repeat     head entry is an auto-repeat (0 = fresh press)
//   count         number of queued entries, 0..4
//   overflow      one-cycle pulse after a push was dropped

// key_event_fifo: small generic synchronous FIFO, power-of-two depth, head read combinationally.
// Latency: a push is visible at head_dat after the write edge when the FIFO was empty.
// Backpressure: a push while full is accepted only with a same-cycle pop; otherwise it is dropped and flagged.
//
// Ports:
//   clk, rstn     clock, async active-low reset (pointers and count only)
//   push, wr_dat  write request and data
//   pop           read request (ignored when empty)
//   head_dat      oldest entry, straight from storage
//   count         occupancy, 0..2**AW
//   drop          combinational: this cycle's push is being discarded
module key_event_fifo #(
  parameter int W  = 6,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [W-1:0]  wr_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   count,
  output logic          drop
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full  = cnt[AW];
  assign empty = (cnt == '0);

  assign do_pop  = pop && !empty;
  // when full, a simultaneous pop frees the slot the write pointer is aiming at
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // storage is deliberately not reset; the read side is qualified by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign count    = cnt;

endmodule

module key_event_queue #(
  parameter logic [25:0] REPEAT_DELAY = 26'd50_000_000,
  parameter logic [25:0] REPEAT_RATE  = 26'd10_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_ready,
  input  logic [4:0] key_code,
  input  logic       pop,
  output logic       ev_valid,
  output logic [4:0] ev_code,
  output logic       ev_repeat,
  output logic [2:0] count,
  output logic       overflow
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  typedef struct packed {
    logic       rpt;
    logic [4:0] code;
  } entry_t;

  // the timer is loaded with N-1 and fires when it reads 0, giving N-cycle spacing
  localparam logic [25:0] DELAY_LOAD = REPEAT_DELAY - 26'd1;
  localparam logic [25:0] RATE_LOAD  = REPEAT_RATE - 26'd1;

  state_t      state_q, state_d;
  logic [25:0] timer_q, timer_d;
  logic [4:0]  cur_q, cur_d;
  logic        push;
  entry_t      push_ent;
  entry_t      head;
  logic        drop;
  logic        key_valid;

  // row 7 is the scanner's "no key" encoding even with key_ready set
  assign key_valid = key_ready && (key_code[4:2] != 3'h7);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cur_d         = cur_q;
    push          = 1'b0;
    push_ent.rpt  = 1'b0;
    push_ent.code = key_code;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          push    = 1'b1;
          cur_d   = key_code;
          timer_d = DELAY_LOAD;
          state_d = ST_HELD;
        end
      end
      ST_HELD, ST_REPEAT: begin
        if (!key_valid) begin
          state_d = ST_IDLE;
        end else if (key_code != cur_q) begin
          // rolling onto another key restarts the press/repeat sequence
          push    = 1'b1;
          cur_d   = key_code;
          timer_d = DELAY_LOAD;
          state_d = ST_HELD;
        end else if (timer_q == '0) begin
          push          = 1'b1;
          push_ent.rpt  = 1'b1;
          push_ent.code = cur_q;
          timer_d       = RATE_LOAD;
          state_d       = ST_REPEAT;
        end else begin
          timer_d = timer_q - 26'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  key_event_fifo #(
    .W  (6),
    .AW (2)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .wr_dat   (push_ent),
    .pop      (pop),
    .head_dat (head),
    .count    (count),
    .drop     (drop)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) overflow <= 1'b0;
    else       overflow <= drop;
  end

  assign ev_valid  = (count != 3'd0);
  assign ev_code   = head.code;
  // storage is not cleared by reset, so the repeat flag is qualified by occupancy
  assign ev_repeat = ev_valid && head.rpt;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with REPEAT_DELAY=8, REPEAT_RATE=4.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_key_event_queue;

  logic       clk;
  logic       rstn;
  logic       key_ready;
  logic [4:0] key_code;
  logic       pop;
  logic       ev_valid;
  logic [4:0] ev_code;
  logic       ev_repeat;
  logic [2:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  key_event_queue #(
    .REPEAT_DELAY (26'd8),
    .REPEAT_RATE  (26'd4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_ready (key_ready),
    .key_code  (key_code),
    .pop       (pop),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_repeat (ev_repeat),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       kr;
    logic [4:0] code;
    logic       pop;
    logic       vld;
    logic [4:0] ecode;
    logic       rep;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tab_a [12];
  vec_t tab_full [5];
  vec_t tab_c [3];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic kr, input logic [4:0] code, input logic p);
    key_ready = kr;
    key_code  = code;
    pop       = p;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [4:0] ecode,
                         input logic rep, input logic [2:0] cnt, input logic ovf);
    chk({tag, ".valid"}, {7'd0, ev_valid}, {7'd0, vld});
    chk({tag, ".count"}, {5'd0, count}, {5'd0, cnt});
    chk({tag, ".ovf"}, {7'd0, overflow}, {7'd0, ovf});
    chk({tag, ".rep"}, {7'd0, ev_repeat}, {7'd0, rep});
    if (vld) chk({tag, ".code"}, {3'd0, ev_code}, {3'd0, ecode});
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    drive(v.kr, v.code, v.pop);
    step();
    chk_out(tag, v.vld, v.ecode, v.rep, v.cnt, v.ovf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // single-table sequence: invalid row, empty pops, press with pop on empty,
    // short hold, push+pop at count 1, row-7 acting as release from HELD
    //              kr    code   pop   vld   ecode  rep   cnt   ovf
    tab_a[0]  = '{1'b1, 5'h1C, 1'b0, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    tab_a[1]  = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    tab_a[2]  = '{1'b1, 5'h09, 1'b1, 1'b1, 5'h09, 1'b0, 3'd1, 1'b0};
    tab_a[3]  = '{1'b1, 5'h09, 1'b0, 1'b1, 5'h09, 1'b0, 3'd1, 1'b0};
    tab_a[4]  = '{1'b1, 5'h09, 1'b0, 1'b1, 5'h09, 1'b0, 3'd1, 1'b0};
    tab_a[5]  = '{1'b0, 5'h00, 1'b0, 1'b1, 5'h09, 1'b0, 3'd1, 1'b0};
    tab_a[6]  = '{1'b1, 5'h0A, 1'b1, 1'b1, 5'h0A, 1'b0, 3'd1, 1'b0};
    tab_a[7]  = '{1'b1, 5'h1C, 1'b0, 1'b1, 5'h0A, 1'b0, 3'd1, 1'b0};
    tab_a[8]  = '{1'b1, 5'h0A, 1'b0, 1'b1, 5'h0A, 1'b0, 3'd2, 1'b0};
    tab_a[9]  = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h0A, 1'b0, 3'd1, 1'b0};
    tab_a[10] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};
    tab_a[11] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};

    // queue holds [0E/0, 0E/1, 0E/1, 0E/1]: new press + pop while full, then drain
    tab_full[0] = '{1'b1, 5'h03, 1'b1, 1'b1, 5'h0E, 1'b1, 3'd4, 1'b0};
    tab_full[1] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h0E, 1'b1, 3'd3, 1'b0};
    tab_full[2] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h0E, 1'b1, 3'd2, 1'b0};
    tab_full[3] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h03, 1'b0, 3'd1, 1'b0};
    tab_full[4] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};

    // queue holds [01/0, 12/0, 12/1]: drain
    tab_c[0] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h12, 1'b0, 3'd2, 1'b0};
    tab_c[1] = '{1'b0, 5'h00, 1'b1, 1'b1, 5'h12, 1'b1, 3'd1, 1'b0};
    tab_c[2] = '{1'b0, 5'h00, 1'b1, 1'b0, 5'h00, 1'b0, 3'd0, 1'b0};

    rstn = 1'b0;
    drive(1'b0, 5'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 5'h00, 1'b0, 3'd0, 1'b0);
    rstn = 1'b1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("tabA[%0d]", i), tab_a[i]);

    // hold 0E for t=0..20: pushes at 0, 8, 12, 16; drop at 20
    for (int t = 0; t <= 20; t++) begin
      int exp_cnt;
      drive(1'b1, 5'h0E, 1'b0);
      step();
      exp_cnt = 1 + int'(t >= 8) + int'(t >= 12) + int'(t >= 16);
      chk_out($sformatf("hold0E[t=%0d]", t), 1'b1, 5'h0E, 1'b0, 3'(exp_cnt), 1'b0 ^ (t == 20));
    end

    for (int i = 0; i < 5; i++) run_vec($sformatf("full[%0d]", i), tab_full[i]);

    // hold 01 for t=0..4, roll onto 12 at t=5; first 12 repeat at t=13
    for (int t = 0; t <= 13; t++) begin
      int exp_cnt;
      drive(1'b1, (t < 5) ? 5'h01 : 5'h12, 1'b0);
      step();
      exp_cnt = 1 + int'(t >= 5) + int'(t >= 13);
      chk($sformatf("roll[t=%0d].count", t), {5'd0, count}, 8'(exp_cnt));
    end
    chk_out("roll.head", 1'b1, 5'h01, 1'b0, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) run_vec($sformatf("rollDrain[%0d]", i), tab_c[i]);

    // hold 05 until 3 entries are queued, then reset mid-cycle with the key still down
    for (int t = 0; t <= 12; t++) begin
      int exp_cnt;
      drive(1'b1, 5'h05, 1'b0);
      step();
      exp_cnt = 1 + int'(t >= 8) + int'(t >= 12);
      chk($sformatf("hold05[t=%0d].count", t), {5'd0, count}, 8'(exp_cnt));
    end
    #2;
    rstn = 1'b0;
    #1;
    chk_out("asyncReset", 1'b0, 5'h00, 1'b0, 3'd0, 1'b0);
    step();
    chk_out("inReset", 1'b0, 5'h00, 1'b0, 3'd0, 1'b0);
    rstn = 1'b1;
    step();
    chk_out("afterReset", 1'b1, 5'h05, 1'b0, 3'd1, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      step();
      chk_out($sformatf("afterReset[t=%0d]", t), 1'b1, 5'h05, 1'b0,
              (t == 8) ? 3'd2 : 3'd1, 1'b0);
    end
    drive(1'b0, 5'h00, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
